prvp_token_rr_arbiter: RTL
==========================

// Module: prvp_token_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one buffer write port among NUM_REQ requesters.
//  Priority is held in a one-hot rotating token ring. The owner keeps the grant for a
//  whole burst. A hold counter bounds the ownership time and preempts the owner at the limit.
//  Sits in front of the c2c dual-clock buffer, on its write-clock side.
// PARAMETERS
//  NUM_REQ   4   number of requesters, >=2
//  MAX_HOLD  16  max accepted beats per ownership; 0 = unlimited (no preemption)
//  IDX_W     2   width of grant_idx, = clog2(NUM_REQ)
//  HOLD_W    5   width of the hold counter, = clog2(MAX_HOLD+1)
// PORTS
//  clk         in   1        clock
//  rst         in   1        reset; one clock; reset is synchronous and active-high
//  enable      in   1        1 = new grants allowed; does not revoke the current owner
//  req         in   NUM_REQ  per-requester request/valid; a beat = req[i]&grant[i]
//  last        in   NUM_REQ  final beat of the burst; sampled only with an accepted beat
//  grant       out  NUM_REQ  registered one-hot grant, or all zero
//  grant_idx   out  IDX_W    binary index of the owner; 0 when grant==0
//  grant_vld   out  1        |grant
//  preempt     out  1        1-cycle pulse, the cycle after a forced release
//  token       out  NUM_REQ  current priority token (one-hot), debug/observe
// BEHAVIOUR
//  Reset (rst=1 at an edge): grant=0, grant_idx=0, grant_vld=0, preempt=0,
//   token=1 (bit 0), hold_cnt=0, FSM=IDLE. Reset asserted during OWN drops the grant
//   at that edge. No beat is accepted in that cycle.
//  FSM, 2 states:
//   IDLE: if enable & |req, the winner is the first set req bit at or after the token
//    position, searching upward with wrap. At the edge: grant<=onehot(winner),
//    hold_cnt<=0, go to OWN. Latency is req->grant = 1 cycle.
//    If enable=0 or req=0, stay in IDLE with grant=0.
//   OWN: a beat is accepted each cycle that req[o]&grant[o] is true; hold_cnt+=1 per beat.
//    The owner is released at the edge when any of these holds:
//     (a) accepted beat with last[o]=1: normal release
//     (b) req[o]=0: abandon, no beat is counted
//     (c) MAX_HOLD!=0, accepted beat, and hold_cnt==MAX_HOLD-1: forced release.
//         Raise preempt for the next cycle. If (a) and (c) coincide, (a) wins and preempt=0.
//    On release: grant<=0, token<=rotl(grant,1) (wraps MSB->bit0), go to IDLE.
//  Turnaround: at least one cycle with grant=0 between owners, including re-grant of the same
//   requester. Back-to-back bursts therefore cost 1 idle cycle.
//  The token changes only on release and never on reset-free idle cycles. It is always exactly one-hot.
//  enable falling during OWN has no effect until the release. After that, IDLE waits for enable.
//  req/last bits of non-owners are ignored during OWN.
//  hold_cnt saturates and never wraps. When MAX_HOLD=0 it is not compared.
//  last without req, or last on a non-owner, is ignored.
//  Outputs are pure registers. There is no combinational path from req/last to grant.
// STRUCTURE
//  Shared header prvp_c2c_defines.vh: FSM encodings (ST_IDLE=1'b0, ST_OWN=1'b1),
//   default NUM_REQ/MAX_HOLD.
//  Sub-module prvp_sync_token_ring: one-hot rotate-by-1 register with sync active-high
//   reset and an enable input. Width=NUM_REQ, reset value 1. Its enable is driven by the
//   release strobe, and its next state is loaded from rotl(grant).
//  The winner search (rotate-by-token, priority-encode, rotate back) and the FSM/hold
//   counter are in the top level.
// TESTING (NUM_REQ=4, MAX_HOLD=4 unless stated)
//  1 reset: hold rst=1 for 2 cycles -> grant=0000, grant_idx=0, token=0001, preempt=0.
//  2 RR: req=0101 at cycle t -> grant=0001 at t+1. last[0] at t+3 -> grant=0000 at t+4,
//    token=0010. grant=0100 at t+5.
//  3 wrap: token=1000, req=1001 -> grant=1000. After release, token=0001 -> next grant=0001.
//  4 preempt: req=0001 constant, last=0 -> 4 beats, grant=0 at the 5th cycle, preempt=1
//    for 1 cycle, token=0010, then re-grant 0001. Repeat with last on the 4th beat -> preempt=0.
//  5 enable/abandon: enable=0, req=0010 -> grant stays 0. enable=1 -> grant=0010 next
//    cycle. Drop enable, then drop req[1] -> grant=0 next cycle, token=0100, preempt=0.
//  6 reset mid-burst: rst=1 while grant=0100 with 2 beats taken -> grant=0000, token=0001,
//    hold_cnt=0. After rst=0, the arbiter re-arbitrates from bit 0.

Source files
------------

// File: rtl/prvp_token_rr_arbiter_pkg.sv
// Shared encodings and defaults for the token round-robin write-port arbiter.
package prvp_token_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_MAX_HOLD = 16;

endpackage

// File: rtl/prvp_sync_token_ring.sv
// One-hot priority token register; loads a new position only when enabled.
module prvp_sync_token_ring #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)     q_q <= WIDTH'(1);
        else if (en_i) q_q <= d_i;
    end

    assign q_o = q_q;

endmodule

// File: rtl/prvp_token_rr_arbiter.sv
// Round-robin arbiter for one buffer write port: burst ownership, one-hot rotating
// token, and a hold counter that forces release after MAX_HOLD accepted beats.
module prvp_token_rr_arbiter
    import prvp_token_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_vld_o,
    output logic               preempt_o,
    output logic [NUM_REQ-1:0] token_o
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W:0]    NREQ_W   = (IDX_W + 1)'(NUM_REQ);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                vld_q, vld_d;
    logic                preempt_q, preempt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [NUM_REQ-1:0]  token;
    logic                release_stb;

    // Winner search: rotate req so the token position lands at bit 0,
    // take the lowest set bit, then add the token position back.
    logic [IDX_W-1:0]     ptr, k_sel, win;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot, win_oh;
    logic [IDX_W:0]       sum;
    logic                 hit;

    always_comb begin
        ptr = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (token[i]) ptr = IDX_W'(i);
        dbl   = {req_i, req_i} >> ptr;
        rot   = dbl[NUM_REQ-1:0];
        hit   = 1'b0;
        k_sel = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (rot[k]) begin
                hit   = 1'b1;
                k_sel = IDX_W'(k);
            end
        sum = {1'b0, ptr} + {1'b0, k_sel};
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        win         = sum[IDX_W-1:0];
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

    logic own_req, own_last, beat, rel_norm, rel_abdn, rel_force;

    assign own_req   = |(req_i & grant_q);
    assign own_last  = |(last_i & grant_q);
    assign beat      = own_req;
    assign rel_norm  = beat & own_last;
    assign rel_abdn  = ~own_req;
    assign rel_force = (MAX_HOLD != 0) && beat && (hold_q == HOLD_LIM);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        vld_d       = vld_q;
        hold_d      = hold_q;
        preempt_d   = 1'b0;
        release_stb = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable_i && hit) begin
                    grant_d = win_oh;
                    idx_d   = win;
                    vld_d   = 1'b1;
                    hold_d  = '0;
                    state_d = ST_OWN;
                end
            end
            ST_OWN: begin
                if (beat && hold_q != '1) hold_d = hold_q + 1'b1;
                if (rel_norm || rel_abdn || rel_force) begin
                    release_stb = 1'b1;
                    preempt_d   = rel_force & ~rel_norm;
                    grant_d     = '0;
                    idx_d       = '0;
                    vld_d       = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            vld_q     <= 1'b0;
            preempt_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            vld_q     <= vld_d;
            preempt_q <= preempt_d;
            hold_q    <= hold_d;
        end
    end

    // Token advances past the releasing owner; reset inside the ring wins over the strobe.
    prvp_sync_token_ring #(.WIDTH(NUM_REQ)) u_ring (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (release_stb),
        .d_i   ({grant_q[NUM_REQ-2:0], grant_q[NUM_REQ-1]}),
        .q_o   (token)
    );

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign grant_vld_o = vld_q;
    assign preempt_o   = preempt_q;
    assign token_o     = token;

endmodule
